aes_round_sequencer: RTL and testbench
======================================

Name: aes_round_sequencer

Overview:
- Iterative AES encryption core: one full cipher round per clock, reusing a single SubBytes/ShiftRows/MixColumns/AddRoundKey datapath for all rounds.
- Sequences the round counter, requests the round key for each round from the key-schedule store, and bypasses MixColumns in the final round.
- Sits between the block-level valid/ready stream interface and the round-key memory.

Parameters:
- NR, 10, number of rounds. Legal values are 10, 12, 14 (AES-128/192/256). Any other value fails elaboration.
- RKW, 4, width of the round-key index. Must satisfy 2**RKW > NR.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  plaintext block available
- in_ready  out  1  sequencer accepts a block this cycle
- in_data  in  128  plaintext. Byte 0 is in [127:120]. Column c is [127-32c -: 32], row 0 in the top byte.
- rk_idx  out  RKW  round-key index requested this cycle
- rk_data  in  128  round key for rk_idx, valid combinationally in the same cycle, same byte order as in_data
- out_valid  out  1  ciphertext valid
- out_ready  in  1  downstream accepts the ciphertext
- out_data  out  128  ciphertext, same byte order
- busy  out  1  a block is in flight (states ROUND or DONE)

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - state=IDLE, round=0, state register=0.
  - Outputs: in_ready=0 while rst_n low, then 1 in IDLE. out_valid=0, out_data=0, busy=0, rk_idx=0.
- FSM states:
  - IDLE:
    - in_ready=1, rk_idx=0.
    - On in_valid: st <= in_data ^ rk_data (round key 0); round <= 1; go to ROUND.
  - ROUND:
    - in_ready=0, rk_idx=round.
    - Every cycle: st <= AddRoundKey(MixColumns(ShiftRows(SubBytes(st))), rk_data).
    - If round==NR, MixColumns is skipped, the register loads the final result, and the FSM goes to DONE.
    - Otherwise round <= round+1.
  - DONE:
    - out_valid=1, out_data=st. out_data is held stable until the handshake completes.
    - On out_ready: out_valid drops next cycle, go to IDLE.
- MixColumns math:
  - Per-column GF(2^8) multiply by {02,03,01,01} circulant.
  - xtime(a) = (a<<1) ^ (a[7] ? 8'h1b : 0); mul3(a) = xtime(a) ^ a.
  - All arithmetic is 8-bit XOR, with no carries.
- Latency: input handshake in cycle T → out_valid in cycle T+NR+1. Throughput is one block per NR+2 cycles when out_ready is held high.
- Boundaries:
  - No back-to-back overlap: in_ready=0 in ROUND and DONE. in_valid asserted there is ignored, and in_data is not sampled.
  - out_ready asserted outside DONE has no effect.
  - out_ready low in DONE: stall indefinitely, out_data stable, rk_idx=0.
  - Round counter never exceeds NR and does not wrap.
  - rst_n asserted mid-block: immediate return to IDLE, partial state discarded, out_valid=0 asynchronously. No block is emitted after release.
  - rk_data is sampled only in IDLE (on accept) and ROUND. Its value is don't-care elsewhere.

Decomposition:
- Shared package aes_pkg holds:
  - the SBOX constant table
  - functions xtime, mul3, sub_bytes, shift_rows
  - AES_BLOCK_W=128 and the enum round_state_t {IDLE, ROUND, DONE}
- One sub-module, aes_mix_column: a purely combinational 32-bit single-column mixer, instantiated 4×.
- The sequencer owns the FSM, counter and state register.

Test Plan:
- FIPS-197 App. C.1 vector:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f (bench supplies expanded keys by rk_idx), plaintext 00112233445566778899aabbccddeeff.
  - Required: out_data=69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 11 cycles after the accept.
- FIPS-197 App. B vector:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, plaintext 3243f6a8885a308d313198a2e0370734.
  - Required: 3925841d02dc09fbdc118597196a0b32.
  - Also check rk_idx sequence 0,1,…,10 on consecutive cycles.
- Backpressure:
  - Stimulus: hold out_ready=0 for 20 cycles after out_valid.
  - Required: out_data stable, in_ready=0, a second in_valid ignored. After out_ready=1, next-cycle in_ready=1, and the second block is then accepted and correct.
- Mid-operation reset:
  - Stimulus: assert rst_n=0 at round 5, release, then run App. B again.
  - Required: outputs go to 0 immediately, no spurious out_valid, and the App. B result is correct.
- NR=14 build (AES-256 FIPS-197 C.3):
  - Stimulus: key 00…1f, plaintext 00112233…eeff.
  - Required: 8ea2b7ca516745bfeafc49904b496089, latency 15 cycles.
- Streaming with out_ready tied to 1:
  - Required: 100 random blocks match the reference model, one block per NR+2 cycles.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: block width, sequencer state encoding, S-box table
// and the byte-wise SubBytes / ShiftRows / GF(2^8) helpers used by the round datapath.
package aes_pkg;

  localparam int AES_BLOCK_W = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } round_state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Multiply by {02} in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by {03} = {02} xor {01}.
  function automatic logic [7:0] mul3(input logic [7:0] a);
    return xtime(a) ^ a;
  endfunction

  // Byte b of the block sits at [127-8b -: 8]; b = 4*column + row.
  function automatic logic [AES_BLOCK_W-1:0] sub_bytes(input logic [AES_BLOCK_W-1:0] s);
    logic [AES_BLOCK_W-1:0] r;
    r = '0;
    for (int b = 0; b < 16; b++) r[127-8*b -: 8] = SBOX[s[127-8*b -: 8]];
    return r;
  endfunction

  // Row r rotates left by r columns: out(r,c) = in(r,(c+r) mod 4).
  function automatic logic [AES_BLOCK_W-1:0] shift_rows(input logic [AES_BLOCK_W-1:0] s);
    logic [AES_BLOCK_W-1:0] r;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        r[127-8*(4*c+w) -: 8] = s[127-8*(4*((c+w)%4)+w) -: 8];
    return r;
  endfunction

endpackage

// File: rtl/aes_mix_column.sv
// Combinational MixColumns for one 32-bit column (row 0 in the top byte),
// using the {02,03,01,01} circulant over GF(2^8).
module aes_mix_column
  import aes_pkg::*;
(
  input  logic [31:0] col,
  output logic [31:0] mixed
);

  logic [7:0] a0, a1, a2, a3;

  assign a0 = col[31:24];
  assign a1 = col[23:16];
  assign a2 = col[15:8];
  assign a3 = col[7:0];

  assign mixed = {xtime(a0) ^ mul3(a1) ^ a2 ^ a3,
                  a0 ^ xtime(a1) ^ mul3(a2) ^ a3,
                  a0 ^ a1 ^ xtime(a2) ^ mul3(a3),
                  mul3(a0) ^ a1 ^ a2 ^ xtime(a3)};

endmodule

// File: rtl/aes_round_sequencer.sv
// Iterative AES encryption core: one full round per clock through a single
// shared datapath. Fetches round keys by index and skips MixColumns in the last round.
module aes_round_sequencer
  import aes_pkg::*;
#(
  parameter int NR  = 10,
  parameter int RKW = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_BLOCK_W-1:0] in_data,
  output logic [RKW-1:0]         rk_idx,
  input  logic [AES_BLOCK_W-1:0] rk_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_BLOCK_W-1:0] out_data,
  output logic                   busy
);

  if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
    $error("aes_round_sequencer: NR must be 10, 12 or 14");
  end
  if ((1 << RKW) <= NR) begin : g_bad_rkw
    $error("aes_round_sequencer: RKW too narrow to index round NR");
  end

  localparam logic [RKW-1:0] LAST_ROUND = RKW'(NR);

  round_state_t           state;
  logic [RKW-1:0]         round;
  logic [AES_BLOCK_W-1:0] st;
  logic [AES_BLOCK_W-1:0] sr;
  logic [AES_BLOCK_W-1:0] mc;
  logic [AES_BLOCK_W-1:0] round_out;

  // Round datapath: SubBytes, ShiftRows, MixColumns per column, then AddRoundKey.
  assign sr = shift_rows(sub_bytes(st));

  for (genvar c = 0; c < 4; c++) begin : g_mix
    aes_mix_column u_mix (
      .col   (sr[127-32*c -: 32]),
      .mixed (mc[127-32*c -: 32])
    );
  end

  assign round_out = ((round == LAST_ROUND) ? sr : mc) ^ rk_data;

  // in_ready is gated by rst_n so it stays low for the whole reset window.
  assign in_ready  = rst_n && (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_data  = (state == DONE) ? st : '0;
  assign busy      = (state != IDLE);
  assign rk_idx    = (state == ROUND) ? round : '0;

  // Sequencer FSM: accept with key 0, run NR rounds, hold the result until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      round <= '0;
      st    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            st    <= in_data ^ rk_data;
            round <= RKW'(1);
            state <= ROUND;
          end
        end
        ROUND: begin
          st <= round_out;
          if (round == LAST_ROUND) state <= DONE;
          else                     round <= round + 1'b1;
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
            round <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: FIPS-197 known answers (AES-128 and AES-256),
// backpressure, mid-block reset and a random stream against a bench-side AES model.
`timescale 1ns/1ps
module tb_aes_round_sequencer;

  localparam int NR  = 10;
  localparam int RKW = 4;

  typedef logic [127:0] rk_arr_t [0:15];
  typedef struct {
    logic [127:0] exp;
    int           acc;
  } sb_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n = 1'b0;
  logic         in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] in_data, rk_data, out_data;
  logic [RKW-1:0] rk_idx;

  logic         in_valid14, in_ready14, out_valid14, out_ready14, busy14;
  logic [127:0] in_data14, rk_data14, out_data14;
  logic [RKW-1:0] rk_idx14;

  rk_arr_t rk10, rk14;
  assign rk_data   = rk10[rk_idx];
  assign rk_data14 = rk14[rk_idx14];

  aes_round_sequencer #(.NR(NR), .RKW(RKW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .rk_idx(rk_idx), .rk_data(rk_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  aes_round_sequencer #(.NR(14), .RKW(RKW)) dut14 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid14), .in_ready(in_ready14), .in_data(in_data14),
    .rk_idx(rk_idx14), .rk_data(rk_data14), .out_valid(out_valid14), .out_ready(out_ready14),
    .out_data(out_data14), .busy(busy14)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp_v);
    end
  endtask

  // ---------------- reference model (S-box derived from the field inverse) ----------------
  logic [7:0] sbt [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbt[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbt[w[31:24]], sbt[w[23:16]], sbt[w[15:8]], sbt[w[7:0]]};
  endfunction

  task automatic expand(input logic [255:0] key, input int nk, input int nr, output rk_arr_t rk);
    logic [31:0] w [60];
    logic [31:0] tmp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = subword({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h000000};
        rc  = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        tmp = subword(tmp);
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int r = 0; r < 16; r++) begin
      if (r <= nr) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      else         rk[r] = '0;
    end
  endtask

  function automatic logic [127:0] ref_enc(input logic [127:0] pt, input rk_arr_t rk, input int nr);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] res;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk[0][127-8*i -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sbt[s[i]];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) t[4*c+w] = s[4*((c+w)%4)+w];
      for (int c = 0; c < 4; c++) begin
        if (r != nr) begin
          s[4*c]   = gmul(8'h02, t[4*c]) ^ gmul(8'h03, t[4*c+1]) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gmul(8'h02, t[4*c+1]) ^ gmul(8'h03, t[4*c+2]) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(8'h02, t[4*c+2]) ^ gmul(8'h03, t[4*c+3]);
          s[4*c+3] = gmul(8'h03, t[4*c]) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(8'h02, t[4*c+3]);
        end else begin
          for (int w = 0; w < 4; w++) s[4*c+w] = t[4*c+w];
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[r][127-8*i -: 8];
    end
    res = '0;
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- scoreboard monitor ----------------
  sb_t          sbq[$];
  logic         prev_valid = 1'b0;
  logic         prev_ready = 1'b0;
  logic [127:0] prev_data  = '0;

  always @(negedge clk) begin
    if (out_valid) begin
      if (sbq.size() == 0) begin
        check("no_spurious_out_valid", 128'(out_valid), 128'd0);
      end else begin
        if (!prev_valid) check("latency", 128'(cyc - sbq[0].acc), 128'(NR + 1));
        if (prev_valid && !prev_ready) check("out_data_stable", out_data, prev_data);
        if (out_ready) begin
          check("out_data", out_data, sbq[0].exp);
          void'(sbq.pop_front());
        end
      end
    end
    prev_valid = out_valid;
    prev_ready = out_ready;
    prev_data  = out_data;
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [127:0] pt, input logic [127:0] exp_v, input bit chk_rk,
                      input bit keep, output int acc, output int waits);
    sb_t e;
    in_data  = pt;
    in_valid = 1'b1;
    waits    = 0;
    acc      = -1;
    @(negedge clk);
    while (!in_ready && waits < 500) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("accept_timeout", 128'(in_ready), 128'd1);
      in_valid = 1'b0;
      @(posedge clk); #1;
      return;
    end
    acc   = cyc;
    e.exp = exp_v;
    e.acc = cyc;
    sbq.push_back(e);
    if (chk_rk) check("rk_idx_accept", 128'(rk_idx), 128'd0);
    @(posedge clk); #1;
    if (!keep) begin
      in_valid = 1'b0;
      in_data  = {$urandom, $urandom, $urandom, $urandom};
    end
    if (chk_rk) begin
      for (int k = 1; k <= NR; k++) begin
        @(negedge clk);
        check("rk_idx_round", 128'(rk_idx), 128'(k));
      end
      @(negedge clk);
      check("rk_idx_done", 128'(rk_idx), 128'd0);
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("scoreboard_drained", 128'(sbq.size()), 128'd0);
    #1;
  endtask

  // ---------------- main sequence ----------------
  logic [127:0] pa, pb, pt;
  int acc, waits, last, n;

  initial begin
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    in_valid14 = 1'b0; in_data14 = '0; out_ready14 = 1'b0;
    build_sbox();
    expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10, rk10);
    expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14, rk14);

    // reset state
    #1;
    check("rst_in_ready", 128'(in_ready), 128'd0);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_out_data", out_data, 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_rk_idx", 128'(rk_idx), 128'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("idle_in_ready", 128'(in_ready), 128'd1);
    check("idle_busy", 128'(busy), 128'd0);
    @(posedge clk); #1;

    // FIPS-197 C.1
    out_ready = 1'b1;
    send(128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b0, 1'b0, acc, waits);
    check("busy_in_round", 128'(busy), 128'd1);
    drain();

    // FIPS-197 App. B with round-key index trace
    expand({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4, 10, rk10);
    send(128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32, 1'b1, 1'b0, acc, waits);
    drain();

    // backpressure: 20 stall cycles with a second block waiting
    out_ready = 1'b0;
    pa = {$urandom, $urandom, $urandom, $urandom};
    pb = {$urandom, $urandom, $urandom, $urandom};
    send(pa, ref_enc(pa, rk10, NR), 1'b0, 1'b0, acc, waits);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_out_valid_seen", 128'(out_valid), 128'd1);
    @(posedge clk); #1;
    in_data  = pb;
    in_valid = 1'b1;
    repeat (20) begin
      @(negedge clk);
      check("bp_in_ready_low", 128'(in_ready), 128'd0);
      check("bp_rk_idx", 128'(rk_idx), 128'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(pb, ref_enc(pb, rk10, NR), 1'b0, 1'b0, acc, waits);
    check("bp_accept_next_cycle", 128'(waits), 128'd1);
    drain();

    // reset in the middle of round 5
    send(128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32, 1'b0, 1'b0, acc, waits);
    n = 0;
    while (rk_idx != RKW'(5) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("mid_reset_round5_reached", 128'(rk_idx), 128'd5);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 128'(out_valid), 128'd0);
    check("mid_rst_in_ready", 128'(in_ready), 128'd0);
    check("mid_rst_busy", 128'(busy), 128'd0);
    check("mid_rst_rk_idx", 128'(rk_idx), 128'd0);
    check("mid_rst_out_data", out_data, 128'd0);
    sbq.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    send(128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32, 1'b0, 1'b0, acc, waits);
    drain();

    // AES-256 (FIPS-197 C.3) on the NR=14 instance
    in_data14   = 128'h00112233445566778899aabbccddeeff;
    in_valid14  = 1'b1;
    out_ready14 = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready14 && n < 50) begin
      @(negedge clk);
      n++;
    end
    acc = cyc;
    @(posedge clk); #1;
    in_valid14 = 1'b0;
    check("aes256_busy", 128'(busy14), 128'd1);
    n = 0;
    while (!out_valid14 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("aes256_latency", 128'(cyc - acc), 128'd15);
    check("aes256_out_data", out_data14, 128'h8ea2b7ca516745bfeafc49904b496089);
    @(posedge clk); #1;

    // random stream with out_ready held high
    expand({$urandom, $urandom, $urandom, $urandom, 128'h0}, 4, 10, rk10);
    last = 0;
    for (int i = 0; i < 100; i++) begin
      pt = {$urandom, $urandom, $urandom, $urandom};
      send(pt, ref_enc(pt, rk10, NR), 1'b0, 1'b1, acc, waits);
      if (i > 0) check("throughput", 128'(acc - last), 128'(NR + 2));
      last = acc;
    end
    in_valid = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at time limit, expected completion");
    $fatal(1, "time limit reached");
  end

endmodule
